pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central stall/flush controller for the 5-stage ARM-subset pipeline. It watches register usage in ID, destinations in EXE and MEM, branch resolution in EXE, and the data-memory handshake in MEM. It drives freeze and flush controls for the PC, IF/ID, ID/EXE and EXE/MEM pipeline registers, counts stall and flush events, and flags memory time-outs.

## Interface
- MEM_TIMEOUT, 64: cycles in MEM_WAIT before `mem_err` is raised (≥2)
- CNT_W, 16: width of the saturating performance counters
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- forward_en  in  1  1 = forwarding unit present (stall on load-use only); 0 = stall on any RAW
- id_valid  in  1  ID holds a real instruction
- id_src1, id_src2  in  4 each  source register numbers in ID
- id_use_src1, id_use_src2  in  1 each  source actually read
- exe_dest  in  4  EXE destination
- exe_wb_en, exe_mem_r_en  in  1 each  EXE writes back / is a load
- mem_dest  in  4  MEM destination
- mem_wb_en  in  1  MEM writes back
- branch_taken  in  1  branch resolved taken in EXE
- mem_access  in  1  MEM holds a load/store
- mem_ready  in  1  data memory completes this cycle
- freeze_pc, freeze_if_id  out  1 each  hold PC / IF-ID
- flush_if_id, flush_id_exe  out  1 each  load bubble into IF-ID / ID-EXE
- freeze_back  out  1  hold ID-EXE, EXE-MEM, MEM-WB
- mem_err  out  1  sticky memory time-out flag
- stall_cycles, flush_count  out  CNT_W each  saturating counters

## Operation
- FSM states: RUN, MEM_WAIT.
  - RUN → MEM_WAIT when `mem_access & ~mem_ready`.
  - MEM_WAIT → RUN when `mem_ready`.
- `mem_stall = mem_access & ~mem_ready`. This is combinational, identical in both states.
- Data hazard, computed by combinational `hazard_detect`:
  - `m1 = id_use_src1 & (id_src1==exe_dest) & exe_wb_en`, same for src2.
  - `n1/n2` are defined the same way against `mem_dest`/`mem_wb_en`.
  - With `forward_en=1`: `hazard = id_valid & exe_mem_r_en & (m1|m2)`.
  - With `forward_en=0`: `hazard = id_valid & (m1|m2|n1|n2)`.
- Priority, highest first: rst, mem_stall, branch_taken, hazard.
  - mem_stall: `freeze_pc = freeze_if_id = freeze_back = 1`; both flushes 0. A branch or hazard in the same cycle is deferred; it is re-evaluated once the stall drops, because all inputs are held.
  - branch_taken: `flush_if_id = flush_id_exe = 1`; no freezes; any hazard is ignored.
  - hazard: `freeze_pc = freeze_if_id = 1`, `flush_id_exe = 1`, `freeze_back = 0`.
  - Otherwise all controls are 0.
- wait_cnt:
  - Cleared in RUN.
  - Increments each MEM_WAIT cycle with `~mem_ready`, saturating at MEM_TIMEOUT.
  - `mem_err` sets when wait_cnt reaches MEM_TIMEOUT-1 while still waiting, and stays set until rst. The FSM keeps waiting.
- stall_cycles increments on every cycle with `freeze_pc=1`.
- flush_count increments on every cycle with `branch_taken` that is not masked by mem_stall.
- Both counters saturate at all-ones.

## Timing
- All control outputs are Mealy and combinational from current inputs, so there are zero cycles of latency. The pipeline registers sample them on the same edge.
- State, wait_cnt, mem_err and the counters update on the rising clk edge.
- Reset values:
  - State RUN; wait_cnt 0; mem_err 0; stall_cycles 0; flush_count 0.
  - All control outputs evaluate per the inputs, since they are not registered.
- Reset asserted mid MEM_WAIT: the next cycle is RUN with wait_cnt 0 and mem_err 0. Reset overrides the counters in the same cycle.
- The load-use bubble lasts exactly one cycle with forwarding. Without forwarding it lasts up to two cycles: EXE match, then MEM match.
- The cycle in which mem_ready rises has no freeze. The branch/hazard logic applies in that same cycle.

## Structure
- `pipe_ctrl_pkg` holds:
  - the state enum {RUN, MEM_WAIT}
  - `REG_W = 4`
  - the control-bundle struct (five control bits)
- Sub-module `hazard_detect` is purely combinational. Its inputs are the ID, EXE and MEM fields plus forward_en; its output is `hazard`. It is reused by any later dual-issue work.
- The top level contains the FSM, wait counter, priority mux and performance counters.

## Test plan
- Load-use: set forward_en=1, exe_mem_r_en=1, exe_wb_en=1, exe_dest=3, id_src1=3, id_use_src1=1. Required: exactly one cycle of freeze_pc/freeze_if_id/flush_id_exe, and stall_cycles goes 0→1.
- No-forward RAW: set forward_en=0, mem_wb_en=1, mem_dest=5, id_src2=5, id_use_src2=1 (EXE non-matching). Required: hazard controls asserted. With forward_en=1 under the same stimulus, all controls are 0.
- Branch vs hazard: branch_taken=1 together with a load-use match. Required: flush_if_id=flush_id_exe=1, freeze_pc=0, flush_count=1.
- Memory wait: hold mem_access=1 with mem_ready=0 for 5 cycles, then mem_ready=1. Required: freeze_back=1 for 5 cycles, then 0; state returns to RUN; stall_cycles=5. A concurrent branch_taken gives flush_count +1 only in the ready cycle.
- Time-out: set MEM_TIMEOUT=4 and hold mem_ready=0 for 6 cycles. Required: mem_err rises after cycle 4 and stays 1 after mem_ready; only rst clears it.
- Reset mid-wait: assert rst in MEM_WAIT with wait_cnt=2. Required: next cycle is RUN, wait_cnt=0, counters=0, mem_err=0. Also drive 2^CNT_W+3 stall cycles and check that stall_cycles saturates at all-ones.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  localparam int unsigned REG_W = 4;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  // Pipeline-register control bundle driven each cycle.
  typedef struct packed {
    logic freeze_pc;
    logic freeze_if_id;
    logic flush_if_id;
    logic flush_id_exe;
    logic freeze_back;
  } ctrl_t;

endpackage

// File: rtl/hazard_detect.sv
// Combinational RAW hazard check between ID sources and EXE/MEM destinations.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic             forward_en,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_use_src1,
  input  logic             id_use_src2,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_wb_en,
  output logic             hazard
);

  logic m1, m2, n1, n2;

  assign m1 = id_use_src1 & (id_src1 == exe_dest) & exe_wb_en;
  assign m2 = id_use_src2 & (id_src2 == exe_dest) & exe_wb_en;
  assign n1 = id_use_src1 & (id_src1 == mem_dest) & mem_wb_en;
  assign n2 = id_use_src2 & (id_src2 == mem_dest) & mem_wb_en;

  // With forwarding only a load in EXE cannot be bypassed in time.
  always_comb begin
    hazard = 1'b0;
    if (forward_en) hazard = id_valid & exe_mem_r_en & (m1 | m2);
    else            hazard = id_valid & (m1 | m2 | n1 | n2);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller: memory-wait FSM, priority mux of pipeline
// controls, memory time-out flag and saturating stall/flush counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             forward_en,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_use_src1,
  input  logic             id_use_src2,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_wb_en,
  input  logic             branch_taken,
  input  logic             mem_access,
  input  logic             mem_ready,
  output logic             freeze_pc,
  output logic             freeze_if_id,
  output logic             flush_if_id,
  output logic             flush_id_exe,
  output logic             freeze_back,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_t              state_q, state_d;
  ctrl_t               ctrl;
  logic                mem_stall;
  logic                hazard;
  logic [WAIT_W-1:0]   wait_cnt;

  assign mem_stall = mem_access & ~mem_ready;

  hazard_detect u_hazard_detect (
    .forward_en   (forward_en),
    .id_valid     (id_valid),
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_use_src1  (id_use_src1),
    .id_use_src2  (id_use_src2),
    .exe_dest     (exe_dest),
    .exe_wb_en    (exe_wb_en),
    .exe_mem_r_en (exe_mem_r_en),
    .mem_dest     (mem_dest),
    .mem_wb_en    (mem_wb_en),
    .hazard       (hazard)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Next state plus Mealy controls; a memory stall masks branch and hazard.
  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    case (state_q)
      RUN:      if (mem_stall) state_d = MEM_WAIT;
      MEM_WAIT: if (mem_ready) state_d = RUN;
      default:  state_d = RUN;
    endcase
    if (rst) begin
      ctrl = '0;
    end else if (mem_stall) begin
      ctrl.freeze_pc    = 1'b1;
      ctrl.freeze_if_id = 1'b1;
      ctrl.freeze_back  = 1'b1;
    end else if (branch_taken) begin
      ctrl.flush_if_id  = 1'b1;
      ctrl.flush_id_exe = 1'b1;
    end else if (hazard) begin
      ctrl.freeze_pc    = 1'b1;
      ctrl.freeze_if_id = 1'b1;
      ctrl.flush_id_exe = 1'b1;
    end
  end

  assign freeze_pc    = ctrl.freeze_pc;
  assign freeze_if_id = ctrl.freeze_if_id;
  assign flush_if_id  = ctrl.flush_if_id;
  assign flush_id_exe = ctrl.flush_id_exe;
  assign freeze_back  = ctrl.freeze_back;

  // Wait counter only runs while MEM_WAIT is still unanswered; error is sticky.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else if (state_q == MEM_WAIT && !mem_ready) begin
      if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) mem_err <= 1'b1;
      if (wait_cnt != WAIT_W'(MEM_TIMEOUT))     wait_cnt <= wait_cnt + WAIT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (ctrl.freeze_pc && stall_cycles != '1)
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (branch_taken && !mem_stall && flush_count != '1)
        flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios plus random traffic
// checked against a behavioural model of the stall/flush rules.
module tb_pipe_hazard_ctrl;

  localparam int unsigned TO    = 4;
  localparam int unsigned CW    = 8;
  localparam int          MAXC  = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, forward_en, id_valid, id_use_src1, id_use_src2;
  logic [3:0] id_src1, id_src2, exe_dest, mem_dest;
  logic exe_wb_en, exe_mem_r_en, mem_wb_en, branch_taken, mem_access, mem_ready;
  logic freeze_pc, freeze_if_id, flush_if_id, flush_id_exe, freeze_back, mem_err;
  logic [CW-1:0] stall_cycles, flush_count;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .forward_en(forward_en), .id_valid(id_valid),
    .id_src1(id_src1), .id_src2(id_src2), .id_use_src1(id_use_src1),
    .id_use_src2(id_use_src2), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
    .exe_mem_r_en(exe_mem_r_en), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .branch_taken(branch_taken), .mem_access(mem_access), .mem_ready(mem_ready),
    .freeze_pc(freeze_pc), .freeze_if_id(freeze_if_id), .flush_if_id(flush_if_id),
    .flush_id_exe(flush_id_exe), .freeze_back(freeze_back), .mem_err(mem_err),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  typedef struct {
    logic rst, fwd, idv, u1, u2, ewb, eld, mwb, br, ma, mr;
    logic [3:0] s1, s2, ed, md;
  } stim_t;

  typedef struct {
    logic          rst;
    logic [4:0]    ctl;
    logic          err;
    logic [CW-1:0] stall;
    logic [CW-1:0] flush;
  } exp_t;

  exp_t sbq[$];
  bit   drv_done = 1'b0;
  int   n_tests  = 0;
  int   n_fail   = 0;

  // Reference state: whether a memory access is outstanding and for how long.
  bit m_wait = 1'b0;
  int m_waited = 0;
  bit m_err = 1'b0;
  int m_stall = 0, m_flush = 0;

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    s.fwd = 1'b1;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    rst = s.rst; forward_en = s.fwd; id_valid = s.idv;
    id_src1 = s.s1; id_src2 = s.s2; id_use_src1 = s.u1; id_use_src2 = s.u2;
    exe_dest = s.ed; exe_wb_en = s.ewb; exe_mem_r_en = s.eld;
    mem_dest = s.md; mem_wb_en = s.mwb; branch_taken = s.br;
    mem_access = s.ma; mem_ready = s.mr;
  endtask

  // One clock of stimulus: predict this cycle's controls and the registered
  // outputs as they stand now, then advance the model across the next edge.
  task automatic cyc(input stim_t s);
    exp_t e;
    bit ms, raw_exe, raw_mem, hz;
    logic [4:0] c;
    @(negedge clk);
    apply(s);
    ms      = s.ma && !s.mr;
    raw_exe = s.ewb && ((s.u1 && s.s1 == s.ed) || (s.u2 && s.s2 == s.ed));
    raw_mem = s.mwb && ((s.u1 && s.s1 == s.md) || (s.u2 && s.s2 == s.md));
    hz      = s.fwd ? (s.idv && s.eld && raw_exe) : (s.idv && (raw_exe || raw_mem));
    if (s.rst)       c = 5'b00000;
    else if (ms)     c = 5'b11001;
    else if (s.br)   c = 5'b00110;
    else if (hz)     c = 5'b11010;
    else             c = 5'b00000;
    e.rst = s.rst; e.ctl = c; e.err = m_err;
    e.stall = CW'(m_stall); e.flush = CW'(m_flush);
    sbq.push_back(e);
    if (s.rst) begin
      m_wait = 1'b0; m_waited = 0; m_err = 1'b0; m_stall = 0; m_flush = 0;
    end else begin
      if (c[4] && m_stall < MAXC) m_stall++;
      if (s.br && !ms && m_flush < MAXC) m_flush++;
      if (!m_wait) begin
        m_wait = ms;
        m_waited = 0;
      end else if (s.mr) begin
        m_wait = 1'b0;
      end else begin
        m_waited++;
        if (m_waited >= TO) m_err = 1'b1;
      end
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic driver();
    stim_t s;
    for (int i = 0; i < 2; i++) begin s = idle(); s.rst = 1'b1; cyc(s); end
    // Load-use with forwarding
    s = idle(); s.idv = 1; s.eld = 1; s.ewb = 1; s.ed = 4'd3; s.s1 = 4'd3; s.u1 = 1;
    cyc(s); cyc(idle()); cyc(idle());
    // RAW on MEM destination, without then with forwarding
    s = idle(); s.fwd = 0; s.idv = 1; s.mwb = 1; s.md = 4'd5; s.s2 = 4'd5; s.u2 = 1;
    s.ewb = 1; s.ed = 4'd7;
    cyc(s); s.fwd = 1; cyc(s); cyc(idle());
    // Branch together with load-use
    s = idle(); s.idv = 1; s.eld = 1; s.ewb = 1; s.ed = 4'd3; s.s1 = 4'd3; s.u1 = 1;
    s.br = 1;
    cyc(s); cyc(idle());
    // Five-cycle memory wait with a concurrent branch
    s = idle(); s.rst = 1; cyc(s);
    s = idle(); s.ma = 1; s.br = 1;
    for (int i = 0; i < 5; i++) cyc(s);
    s.mr = 1; cyc(s); cyc(idle()); cyc(idle());
    // Time-out: six unanswered cycles, then ready; error must persist
    s = idle(); s.rst = 1; cyc(s);
    s = idle(); s.ma = 1;
    for (int i = 0; i < 6; i++) cyc(s);
    s.mr = 1; cyc(s);
    for (int i = 0; i < 3; i++) cyc(idle());
    // Reset in the middle of a wait, then a fresh wait
    s = idle(); s.ma = 1;
    for (int i = 0; i < 3; i++) cyc(s);
    s.rst = 1; cyc(s);
    cyc(idle()); cyc(idle());
    s = idle(); s.ma = 1;
    for (int i = 0; i < 5; i++) cyc(s);
    s.mr = 1; cyc(s); cyc(idle());
    // Counter saturation
    s = idle(); s.rst = 1; cyc(s);
    s = idle(); s.idv = 1; s.eld = 1; s.ewb = 1; s.ed = 4'd9; s.s2 = 4'd9; s.u2 = 1;
    for (int i = 0; i < (1 << CW) + 3; i++) cyc(s);
    cyc(idle()); cyc(idle());
    // Random traffic
    for (int i = 0; i < 800; i++) begin
      s.rst = ($urandom_range(0, 79) == 0);
      s.fwd = 1'($urandom_range(0, 1));
      s.idv = ($urandom_range(0, 3) != 0);
      s.s1 = 4'($urandom_range(0, 3)); s.s2 = 4'($urandom_range(0, 3));
      s.u1 = 1'($urandom_range(0, 1)); s.u2 = 1'($urandom_range(0, 1));
      s.ed = 4'($urandom_range(0, 3)); s.md = 4'($urandom_range(0, 3));
      s.ewb = 1'($urandom_range(0, 1)); s.eld = 1'($urandom_range(0, 1));
      s.mwb = 1'($urandom_range(0, 1));
      s.br  = ($urandom_range(0, 3) == 0);
      s.ma  = m_wait ? 1'b1 : ($urandom_range(0, 3) == 0);
      s.mr  = ($urandom_range(0, 3) == 0);
      cyc(s);
    end
    cyc(idle());
    drv_done = 1'b1;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sbq.size() == 0) begin
        if (drv_done) break;
        check("scoreboard_item", 32'd0, 32'd1);
      end else begin
        e = sbq.pop_front();
        if (!e.rst)
          check("controls", 32'({freeze_pc, freeze_if_id, flush_if_id, flush_id_exe, freeze_back}),
                32'(e.ctl));
        check("mem_err", 32'(mem_err), 32'(e.err));
        check("stall_cycles", 32'(stall_cycles), 32'(e.stall));
        check("flush_count", 32'(flush_count), 32'(e.flush));
      end
    end
  endtask

  initial begin
    apply(idle());
    rst = 1'b1;
    fork
      driver();
      monitor();
    join
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d items pending", sbq.size());
    $fatal(1, "timeout");
  end

endmodule
